mc_core_ctrl: RTL

Parametrised multi-cycle control unit for the LoongArch teaching core.
- Replaces the fixed five-state IF/ID/EXE/MEM/WB sequencer with one that handshakes with variable-latency instruction and data SRAMs (req/data_ok).
- Owns the PC register, and detects bus timeouts.
- Keeps cycle and retired-instruction counters.
- Sits between the fetch/decode datapath and the SRAM interfaces. The datapath supplies decoded instruction-class flags and the branch result.

---
 rtl/mc_core_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mc_core_ctrl.sv
// rtl/mc_core_ctrl.sv - multi-cycle sequencer with SRAM req/data_ok handshake, PC, bus timeout and perf counters
module mc_core_ctrl #(
  parameter logic [31:0] PC_RESET = 32'h1c00_0000,
  parameter int          WAIT_MAX = 15,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             resetn,
  output logic             inst_req,
  input  logic             inst_data_ok,
  output logic             data_req,
  output logic             data_wr,
  input  logic             data_data_ok,
  input  logic             dec_is_br,
  input  logic             dec_is_ld,
  input  logic             dec_is_st,
  input  logic             dec_gr_we,
  input  logic             br_taken,
  input  logic [31:0]      br_target,
  output logic [31:0]      pc,
  output logic             ir_we,
  output logic             rf_we,
  output logic [2:0]       state,
  output logic             bus_err,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] inst_cnt
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4,
    S_ERR = 3'd7
  } state_t;

  localparam logic [7:0]       WAIT_LAST = 8'(WAIT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t     state_q;
  state_t     state_d;
  logic [7:0] wait_q;
  logic [7:0] wait_d;
  logic       miss;
  logic       timeout;
  logic       retire;
  logic       set_err;

  // Strobes decode straight from the current state so a reset drops them immediately.
  assign state    = state_q;
  assign inst_req = (state_q == S_IF);
  assign ir_we    = (state_q == S_IF) & inst_data_ok;
  assign data_req = (state_q == S_MEM);
  assign data_wr  = (state_q == S_MEM) & dec_is_st;
  assign rf_we    = (state_q == S_WB) & dec_gr_we;

  assign miss    = ((state_q == S_IF) & ~inst_data_ok) | ((state_q == S_MEM) & ~data_data_ok);
  assign timeout = miss & (wait_q == WAIT_LAST);

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    set_err = 1'b0;
    case (state_q)
      S_IF:  if (inst_data_ok) state_d = S_ID;
      S_ID: begin
        if (dec_is_br) begin
          retire  = 1'b1;
          state_d = S_IF;
        end else begin
          state_d = S_EXE;
        end
      end
      S_EXE: state_d = (dec_is_ld | dec_is_st) ? S_MEM : S_WB;
      S_MEM: begin
        if (data_data_ok) begin
          if (dec_is_st) begin
            retire  = 1'b1;
            state_d = S_IF;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        retire  = 1'b1;
        state_d = S_IF;
      end
      S_ERR: state_d = S_ERR;
      default: begin
        state_d = S_ERR;
        set_err = 1'b1;
      end
    endcase
    if (timeout) begin
      state_d = S_ERR;
      set_err = 1'b1;
    end
  end

  // Any state change or completed handshake restarts the miss count.
  assign wait_d = (miss && !timeout) ? wait_q + 8'd1 : 8'd0;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_IF;
      pc       <= PC_RESET;
      bus_err  <= 1'b0;
      cyc_cnt  <= '0;
      inst_cnt <= '0;
      wait_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cyc_cnt <= cyc_cnt + CNT_ONE;
      if (set_err) bus_err <= 1'b1;
      if (retire) begin
        pc       <= br_taken ? br_target : pc + 32'd4;
        inst_cnt <= inst_cnt + CNT_ONE;
      end
    end
  end

endmodule
